stunir_exec_arbiter: RTL

Round-robin arbiter that shares one STUNIR-generated compute unit (start/done/result handshake) among `NUM_REQ` requesters. It grants one requester at a time, pulses the unit's `start`, waits for `done`, captures `result`, and returns it with a one-cycle acknowledge to the granted requester. It sits between the requesters and a single generated FPGA function module.

---
 rtl/stunir_exec_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/stunir_exec_arbiter.sv
// stunir_exec_arbiter: round-robin arbiter sharing one start/done/result compute
// unit among NUM_REQ requesters. One transaction at a time; each result goes back
// with a one-cycle ack to the granted requester.
// Optional feature macro: STUNIR_ARB_WATCHDOG_EN (WAIT-state timeout with rsp_err).
module stunir_exec_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_i,
    output logic [NUM_REQ-1:0]         ack_o,
    output logic [DATA_W-1:0]          rsp_data_o,
    output logic                       rsp_err_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       busy_o,
    output logic                       unit_start_o,
    input  logic                       unit_done_i,
    input  logic [DATA_W-1:0]          unit_result_i
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     last_grant_q, last_grant_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic               busy_q, busy_d;
    logic               unit_start_q, unit_start_d;
    logic [IDW-1:0]     sel_idx;
    logic [IDW-1:0]     cand;
    logic               sel_vld;
    logic               tmo_hit;

`ifdef STUNIR_ARB_WATCHDOG_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1) > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Watchdog counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Limit reached while still waiting for the unit
    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
    logic unused_tmo;

    assign unused_tmo = (TIMEOUT_CYCLES == 0);
    assign tmo_hit    = 1'b0;
`endif

    // Round-robin pick: first set request upward from last_grant+1, wrapping
    always_comb begin
        sel_idx = last_grant_q;
        sel_vld = 1'b0;
        cand    = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDW'((32'(last_grant_q) + i) % NUM_REQ);
            if (!sel_vld && req_i[cand]) begin
                sel_idx = cand;
                sel_vld = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stale unit_done is only looked at in WAIT
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (sel_vld) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT:   if (unit_done_i || tmo_hit) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values, registered below so every port is a flop
    always_comb begin
        ack_d        = '0;
        unit_start_d = 1'b0;
        busy_d       = (state_d != S_IDLE);
        grant_id_d   = grant_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        last_grant_d = last_grant_q;
`ifdef STUNIR_ARB_WATCHDOG_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sel_vld) begin
                    grant_id_d   = sel_idx;
                    unit_start_d = 1'b1;
                end
            end
            S_LAUNCH: begin
`ifdef STUNIR_ARB_WATCHDOG_EN
                cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (unit_done_i) begin
                    rsp_data_d = unit_result_i;
                    rsp_err_d  = 1'b0;
                    ack_d      = NUM_REQ'(1) << grant_id_q;
                end else if (tmo_hit) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    ack_d      = NUM_REQ'(1) << grant_id_q;
                end else begin
`ifdef STUNIR_ARB_WATCHDOG_EN
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            S_RESP: begin
                last_grant_d = grant_id_q;
            end
            default: ;
        endcase
    end

    // Output and bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q        <= '0;
            unit_start_q <= 1'b0;
            busy_q       <= 1'b0;
            grant_id_q   <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            last_grant_q <= IDW'(NUM_REQ - 1);
        end else begin
            ack_q        <= ack_d;
            unit_start_q <= unit_start_d;
            busy_q       <= busy_d;
            grant_id_q   <= grant_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign ack_o        = ack_q;
    assign unit_start_o = unit_start_q;
    assign busy_o       = busy_q;
    assign grant_id_o   = grant_id_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_err_o    = rsp_err_q;

endmodule
